// File: rtl/uart_pkg.sv
// Shared register offsets, STATUS bit positions and FSM encodings for the UART.
// No logic, so no latency.
// No flow control.
package uart_pkg;
    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_DIV    = 2'd3;

    localparam int STS_RXV  = 0;
    localparam int STS_BUSY = 1;
    localparam int STS_OVR  = 2;
    localparam int STS_FERR = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;
endpackage

// File: rtl/uart_baud_cnt.sv
// Loadable 16-bit down-counter: counts val..0, pulses tick at 0 and reloads val.
// tick is combinational from the count; load takes effect on the next edge.
// No flow control; en gates counting.
module uart_baud_cnt (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        load,
    input  logic        en,
    input  logic [15:0] val,
    output logic        tick
);
    logic [15:0] cnt_q, cnt_d;

    assign tick = en & ~load & (cnt_q == 16'd0);

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = val;
        end else if (en) begin
            cnt_d = (cnt_q == 16'd0) ? val : cnt_q - 16'd1;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
endmodule

// File: rtl/uart_dev.sv
// Memory-mapped 8N1 UART: register file, TX and RX FSMs, registered interrupt.
// Reads are combinational; tx falls the cycle after an accepted DATA write.
// No backpressure: DATA writes while busy are dropped, RX overwrites and flags ovr.
module uart_dev
    import uart_pkg::*;
#(
    parameter logic [15:0] DIV_RST = 16'd868,
    parameter logic [15:0] DIV_MIN = 16'd4
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] Addr,
    input  logic        We,
    input  logic [31:0] WData,
    output logic [31:0] RData,
    output logic        IntRq,
    input  logic        rx,
    output logic        tx
);
    uart_state_e tx_state_q, tx_state_d, rx_state_q, rx_state_d;
    logic [7:0]  tx_shift_q, tx_shift_d, rx_shift_q, rx_shift_d, rx_data_q, rx_data_d;
    logic [2:0]  tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
    logic [15:0] div_q, div_d, div_m1, rx_val;
    logic        rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d, rx_prev_q, rx_prev_d;
    logic        rx_valid_q, rx_valid_d, ovr_q, ovr_d, ferr_q, ferr_d;
    logic        rx_ie_q, rx_ie_d, tx_ie_q, tx_ie_d, irq_q, irq_d;
    logic        wr_data, wr_sts, wr_ctrl, wr_div;
    logic        tx_load, tx_tick, tx_busy;
    logic        rx_start, rx_tick, rx_busy, rx_ok, rx_bad;
    logic        unused_bits;

    assign unused_bits = ^{Addr[31:4], Addr[1:0], WData[31:16]};

    assign wr_data = We & (Addr[3:2] == REG_DATA);
    assign wr_sts  = We & (Addr[3:2] == REG_STATUS);
    assign wr_ctrl = We & (Addr[3:2] == REG_CTRL);
    assign wr_div  = We & (Addr[3:2] == REG_DIV);
    assign div_m1  = div_q - 16'd1;

    // RX start bit waits half a bit so later samples land mid-bit.
    assign rx_val  = (rx_state_q == IDLE) ? ({1'b0, div_q[15:1]} - 16'd1) : div_m1;

    uart_baud_cnt u_tx_baud (.Clk(Clk), .Reset(Reset), .load(tx_load), .en(tx_busy),
                             .val(div_m1), .tick(tx_tick));
    uart_baud_cnt u_rx_baud (.Clk(Clk), .Reset(Reset), .load(rx_start), .en(rx_busy),
                             .val(rx_val), .tick(rx_tick));

    always_comb begin
        tx_state_d = tx_state_q;
        case (tx_state_q)
            IDLE:    if (tx_load) tx_state_d = START;
            START:   if (tx_tick) tx_state_d = DATA;
            DATA:    if (tx_tick && tx_bit_q == 3'd7) tx_state_d = STOP;
            STOP:    if (tx_tick) tx_state_d = IDLE;
            default: tx_state_d = IDLE;
        endcase
    end

    always_comb begin
        tx_busy = (tx_state_q != IDLE);
        tx_load = wr_data & (tx_state_q == IDLE);
        case (tx_state_q)
            START:   tx = 1'b0;
            DATA:    tx = tx_shift_q[0];
            default: tx = 1'b1;
        endcase
    end

    always_comb begin
        rx_state_d = rx_state_q;
        case (rx_state_q)
            IDLE:    if (rx_start) rx_state_d = START;
            START:   if (rx_tick) rx_state_d = rx_s2_q ? IDLE : DATA;
            DATA:    if (rx_tick && rx_bit_q == 3'd7) rx_state_d = STOP;
            STOP:    if (rx_tick) rx_state_d = IDLE;
            default: rx_state_d = IDLE;
        endcase
    end

    always_comb begin
        rx_busy  = (rx_state_q != IDLE);
        rx_start = (rx_state_q == IDLE) & rx_prev_q & ~rx_s2_q;
        rx_ok    = (rx_state_q == STOP) & rx_tick & rx_s2_q;
        rx_bad   = (rx_state_q == STOP) & rx_tick & ~rx_s2_q;
    end

    always_comb begin
        tx_shift_d = tx_shift_q;
        tx_bit_d   = tx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_bit_d   = rx_bit_q;
        rx_s1_d    = rx;
        rx_s2_d    = rx_s1_q;
        rx_prev_d  = rx_s2_q;
        if (tx_load) begin
            tx_shift_d = WData[7:0];
            tx_bit_d   = 3'd0;
        end else if (tx_tick && tx_state_q == DATA) begin
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            tx_bit_d   = tx_bit_q + 3'd1;
        end
        if (rx_start) begin
            rx_bit_d = 3'd0;
        end else if (rx_tick && rx_state_q == DATA) begin
            rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
            rx_bit_d   = rx_bit_q + 3'd1;
        end
    end

    // Frame completion is applied after W1C so a same-cycle set wins.
    always_comb begin
        rx_data_d  = rx_ok ? rx_shift_q : rx_data_q;
        rx_valid_d = rx_valid_q;
        ovr_d      = ovr_q;
        ferr_d     = ferr_q;
        if (wr_sts && WData[STS_RXV])  rx_valid_d = 1'b0;
        if (wr_sts && WData[STS_OVR])  ovr_d      = 1'b0;
        if (wr_sts && WData[STS_FERR]) ferr_d     = 1'b0;
        if (rx_ok)                 rx_valid_d = 1'b1;
        if (rx_ok && rx_valid_q)   ovr_d      = 1'b1;
        if (rx_bad)                ferr_d     = 1'b1;
        rx_ie_d = wr_ctrl ? WData[0] : rx_ie_q;
        tx_ie_d = wr_ctrl ? WData[1] : tx_ie_q;
        div_d   = div_q;
        if (wr_div) div_d = (WData[15:0] < DIV_MIN) ? DIV_MIN : WData[15:0];
        irq_d   = (rx_ie_q & rx_valid_q) | (tx_ie_q & ~tx_busy);
    end

    always_comb begin
        RData = '0;
        case (Addr[3:2])
            REG_DATA: RData[7:0] = rx_data_q;
            REG_STATUS: begin
                RData[STS_RXV]  = rx_valid_q;
                RData[STS_BUSY] = tx_busy;
                RData[STS_OVR]  = ovr_q;
                RData[STS_FERR] = ferr_q;
            end
            REG_CTRL: RData[1:0] = {tx_ie_q, rx_ie_q};
            default:  RData[15:0] = div_q;
        endcase
    end

    assign IntRq = irq_q;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            tx_state_q <= IDLE;
            rx_state_q <= IDLE;
            tx_shift_q <= '0;
            tx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_bit_q   <= '0;
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            ovr_q      <= 1'b0;
            ferr_q     <= 1'b0;
            rx_ie_q    <= 1'b0;
            tx_ie_q    <= 1'b0;
            div_q      <= DIV_RST;
            irq_q      <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            rx_state_q <= rx_state_d;
            tx_shift_q <= tx_shift_d;
            tx_bit_q   <= tx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_bit_q   <= rx_bit_d;
            rx_s1_q    <= rx_s1_d;
            rx_s2_q    <= rx_s2_d;
            rx_prev_q  <= rx_prev_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            ovr_q      <= ovr_d;
            ferr_q     <= ferr_d;
            rx_ie_q    <= rx_ie_d;
            tx_ie_q    <= tx_ie_d;
            div_q      <= div_d;
            irq_q      <= irq_d;
        end
    end
endmodule

// File: tb/tb_uart_dev.sv
// Bench for uart_dev: register access, TX framing, RX loopback and error flags.
// Received bytes are checked against a queue filled when each frame is launched.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_uart_dev;
    import uart_pkg::*;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        We = 1'b0;
    logic [31:0] Addr = '0;
    logic [31:0] WData = '0;
    logic [31:0] RData;
    logic        IntRq, tx, rx;
    logic        rx_drv = 1'b1;
    logic        loop_en = 1'b0;
    int          n_chk = 0;
    int          n_err = 0;
    logic [7:0]  rx_q[$];
    logic [31:0] s;
    int          cyc;

    always #5 Clk = ~Clk;
    assign rx = loop_en ? tx : rx_drv;

    uart_dev dut (
        .Clk(Clk), .Reset(Reset), .Addr(Addr), .We(We), .WData(WData),
        .RData(RData), .IntRq(IntRq), .rx(rx), .tx(tx)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge Clk);
        Addr = {28'd0, a, 2'b00}; WData = d; We = 1'b1;
        @(negedge Clk);
        We = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        Addr = {28'd0, a, 2'b00};
        #1 d = RData;
    endtask

    task automatic wait_sts(input int idx, input int budget, input string tag, output int n);
        logic [31:0] st;
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge Clk);
            rd(REG_STATUS, st);
            if (st[idx]) begin n = i; break; end
        end
        if (n < 0) chk({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic send(input logic [7:0] b);
        rx_q.push_back(b);
        wr(REG_DATA, {24'd0, b});
    endtask

    task automatic check_rx(input string tag);
        logic [31:0] d;
        rd(REG_DATA, d);
        if (rx_q.size() == 0) chk({tag, "_empty"}, d, 32'hDEAD);
        else                  chk(tag, d, {24'd0, rx_q.pop_front()});
    endtask

    task automatic drive_frame(input logic [7:0] b, input logic stop_bit);
        rx_drv = 1'b0;
        repeat (8) @(negedge Clk);
        for (int i = 0; i < 8; i++) begin
            rx_drv = b[i];
            repeat (8) @(negedge Clk);
        end
        rx_drv = stop_bit;
        repeat (8) @(negedge Clk);
        rx_drv = 1'b1;
        repeat (2) @(negedge Clk);
    endtask

    // Launch a byte, sample each bit mid-cell and time how long busy stays set.
    task automatic tx_frame(input logic [7:0] b, input int d, input logic inject, input string tag);
        logic [31:0] st;
        logic [9:0]  fr;
        int          idle_at;
        idle_at = -1;
        fr = {1'b1, b, 1'b0};
        wr(REG_DATA, {24'd0, b});
        for (int c = 0; c < 10 * d + 8; c++) begin
            if (inject && c == 20) begin
                Addr = {28'd0, REG_DATA, 2'b00}; WData = 32'hFF; We = 1'b1;
            end else begin
                We = 1'b0;
                rd(REG_STATUS, st);
                if (idle_at < 0 && !st[STS_BUSY]) idle_at = c;
            end
            if (c % d == d / 2 && c < 10 * d)
                chk($sformatf("%s_bit%0d", tag, c / d), {31'd0, tx}, {31'd0, fr[c / d]});
            @(negedge Clk);
        end
        We = 1'b0;
        chk({tag, "_len"}, idle_at, 10 * d);
        chk({tag, "_idle"}, {31'd0, tx}, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge Clk);
        chk("rst_tx", {31'd0, tx}, 32'd1);
        chk("rst_irq", {31'd0, IntRq}, 32'd0);
        Reset = 1'b1;
        @(negedge Clk);
        rd(REG_STATUS, s); chk("rst_sts", s, 32'd0);
        rd(REG_DIV, s);    chk("rst_div", s, 32'd868);
        rd(REG_CTRL, s);   chk("rst_ctrl", s, 32'd0);
        rd(REG_DATA, s);   chk("rst_data", s, 32'd0);

        // Reset in the middle of a start bit.
        wr(REG_DIV, 32'd8);
        wr(REG_DATA, 32'h55);
        #2 chk("mid_tx_low", {31'd0, tx}, 32'd0);
        Reset = 1'b0;
        #1 chk("mid_rst_tx", {31'd0, tx}, 32'd1);
        chk("mid_rst_irq", {31'd0, IntRq}, 32'd0);
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        rd(REG_STATUS, s); chk("mid_rst_sts", s, 32'd0);
        rd(REG_DIV, s);    chk("mid_rst_div", s, 32'd868);

        wr(REG_DIV, 32'd8);
        tx_frame(8'hA5, 8, 1'b1, "tx_a5");

        // Loopback with RX interrupt.
        loop_en = 1'b1;
        wr(REG_CTRL, 32'd1);
        send(8'h3C);
        wait_sts(STS_RXV, 200, "lb", cyc);
        chk("lb_latency", {31'd0, (cyc >= 76 && cyc <= 84)}, 32'd1);
        chk("lb_irq_lag", {31'd0, IntRq}, 32'd0);
        @(negedge Clk);
        chk("lb_irq", {31'd0, IntRq}, 32'd1);
        check_rx("lb_data");
        wr(REG_STATUS, 32'd1);
        rd(REG_STATUS, s); chk("lb_clr_rxv", {31'd0, s[STS_RXV]}, 32'd0);
        @(negedge Clk);
        chk("lb_clr_irq", {31'd0, IntRq}, 32'd0);
        wr(REG_CTRL, 32'd0);

        // Overrun: second byte lands on an unread first.
        send(8'h11);
        wait_sts(STS_RXV, 200, "ovr1", cyc);
        check_rx("ovr_d1");
        repeat (4) @(negedge Clk);
        send(8'h22);
        wait_sts(STS_OVR, 200, "ovr2", cyc);
        check_rx("ovr_d2");
        rd(REG_STATUS, s); chk("ovr_sts", s & 32'hD, 32'h5);
        wr(REG_STATUS, 32'hD);
        repeat (4) @(negedge Clk);
        rd(REG_STATUS, s); chk("ovr_clr", s, 32'd0);
        loop_en = 1'b0;

        // Framing error leaves the holding register alone.
        drive_frame(8'h77, 1'b0);
        wait_sts(STS_FERR, 20, "ferr", cyc);
        rd(REG_STATUS, s); chk("ferr_sts", s, 32'h8);
        rd(REG_DATA, s);   chk("ferr_data", s, 32'h22);
        wr(REG_STATUS, 32'h8);

        rx_q.push_back(8'h5A);
        drive_frame(8'h5A, 1'b1);
        wait_sts(STS_RXV, 20, "man", cyc);
        check_rx("man_data");
        wr(REG_STATUS, 32'h1);

        // Short low glitch must read as a false start.
        @(negedge Clk);
        rx_drv = 1'b0;
        repeat (3) @(negedge Clk);
        rx_drv = 1'b1;
        repeat (30) @(negedge Clk);
        rd(REG_STATUS, s); chk("glitch_sts", s, 32'd0);

        wr(REG_DIV, 32'd1);
        rd(REG_DIV, s); chk("div_clamp", s, 32'd4);
        tx_frame(8'hC3, 4, 1'b0, "tx_d4");
        wr(REG_DIV, 32'd8);

        wr(REG_CTRL, 32'd2);
        chk("txie_irq_lag", {31'd0, IntRq}, 32'd0);
        @(negedge Clk);
        chk("txie_irq", {31'd0, IntRq}, 32'd1);
        wr(REG_CTRL, 32'd0);
        repeat (2) @(negedge Clk);

        // W1C of rx_valid lands on the same edge as the stop-bit sample.
        rx_q.push_back(8'h96);
        @(negedge Clk);
        fork
            drive_frame(8'h96, 1'b1);
            begin
                repeat (77) @(negedge Clk);
                wr(REG_STATUS, 32'h1);
            end
        join
        rd(REG_STATUS, s); chk("w1c_race_rxv", {31'd0, s[STS_RXV]}, 32'd1);
        check_rx("w1c_race_data");

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
